// File: rtl/mips_pkg.sv
// Shared MIPS definitions: jump opcodes and the J-type target helpers used by the fetch/decode queue.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ENTRY_W = 2 * INSTR_W;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // J-type target = {npc[31:28], instr_index, 2'b00}
  localparam int TGT_REGION_W = 4;
  localparam int TGT_INDEX_W  = 26;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
  endfunction

  function automatic logic [INSTR_W-1:0] jump_target(input logic [INSTR_W-1:0] npc,
                                                     input logic [INSTR_W-1:0] instr);
    return {npc[INSTR_W-1 -: TGT_REGION_W], instr[TGT_INDEX_W-1:0], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_store.sv
// Entry storage for if_id_queue: DEPTH x {npc, instr} register array, cleared by async reset.
module ifq_store
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue between fetch and decode; optional early j/jal redirect
// at the queue head when IFQ_JUMP_REDIRECT_EN is defined.
module if_id_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_npc,
  input  logic [31:0] f_instr,
  output logic        stall,
  output logic [31:0] targPC,
  output logic        PCwre,
  input  logic        flush,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_npc,
  output logic [31:0] d_instr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = PTR_W'(DEPTH) == '0 ? {1'b1, {PTR_W{1'b0}}} : (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]     count_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] head;
  logic               push, pop, redirect;

  assign stall   = (count_q == FULL_CNT);
  assign d_valid = (count_q != '0);
  assign d_npc   = d_valid ? head[ENTRY_W-1:INSTR_W] : '0;
  assign d_instr = d_valid ? head[INSTR_W-1:0]       : '0;

  // A flush overrides everything in its cycle, including the pop that would trigger a redirect
  assign pop = d_valid && d_ready && !flush;

`ifdef IFQ_JUMP_REDIRECT_EN
  assign redirect = pop && is_jump(d_instr);
  assign targPC   = redirect ? jump_target(d_npc, d_instr) : '0;
`else
  assign redirect = 1'b0;
  assign targPC   = '0;
`endif

  assign PCwre = redirect;
  assign push  = f_valid && !stall && !flush && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush || redirect) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  ifq_store #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data ({f_npc, f_instr}),
    .rd_ptr  (rd_ptr_q),
    .rd_data (head)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2); jump expectations follow IFQ_JUMP_REDIRECT_EN.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0;
  logic [31:0] f_npc = '0;
  logic [31:0] f_instr = '0;
  logic        flush = 1'b0;
  logic        d_ready = 1'b0;
  logic        stall, PCwre, d_valid;
  logic [31:0] targPC, d_npc, d_instr;

  int tests = 0;
  int fails = 0;

`ifdef IFQ_JUMP_REDIRECT_EN
  localparam bit REDIR = 1'b1;
`else
  localparam bit REDIR = 1'b0;
`endif

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_valid (f_valid),
    .f_npc   (f_npc),
    .f_instr (f_instr),
    .stall   (stall),
    .targPC  (targPC),
    .PCwre   (PCwre),
    .flush   (flush),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d_npc   (d_npc),
    .d_instr (d_instr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rst_d_valid got %h exp 0", d_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %h exp 0", stall); end
    tests++; if (PCwre !== 1'b0) begin fails++; $display("FAIL rst_PCwre got %h exp 0", PCwre); end
    tests++; if (targPC !== 32'h0) begin fails++; $display("FAIL rst_targPC got %h exp 0", targPC); end
    tests++; if (d_npc !== 32'h0) begin fails++; $display("FAIL rst_d_npc got %h exp 0", d_npc); end
    tests++; if (d_instr !== 32'h0) begin fails++; $display("FAIL rst_d_instr got %h exp 0", d_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_fill_drain;
    f_valid = 1'b1; f_npc = 32'h100; f_instr = 32'h2001_0001; d_ready = 1'b0;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fill_stall0 got %h exp 0", stall); end
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL fill_empty got %h exp 0", d_valid); end
    tick;
    tests++; if (d_valid !== 1'b1) begin fails++; $display("FAIL fill_latency got %h exp 1", d_valid); end
    tests++; if (d_instr !== 32'h2001_0001) begin fails++; $display("FAIL fill_head1 got %h exp 20010001", d_instr); end
    f_npc = 32'h104; f_instr = 32'h2002_0002;
    tick;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fill_stall_full got %h exp 1", stall); end
    f_npc = 32'h108; f_instr = 32'h2003_0003;
    tick;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fill_third_held got %h exp 1", stall); end
    tests++; if (d_instr !== 32'h2001_0001) begin fails++; $display("FAIL fill_head_kept got %h exp 20010001", d_instr); end
    d_ready = 1'b1;
    tick;
    tests++; if (d_instr !== 32'h2002_0002) begin fails++; $display("FAIL drain_2nd got %h exp 20020002", d_instr); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL drain_stall got %h exp 0", stall); end
    tick;
    f_valid = 1'b0;
    tests++; if (d_instr !== 32'h2003_0003) begin fails++; $display("FAIL drain_3rd got %h exp 20030003", d_instr); end
    tests++; if (d_npc !== 32'h108) begin fails++; $display("FAIL drain_3rd_npc got %h exp 108", d_npc); end
    tick;
    d_ready = 1'b0;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %h exp 0", d_valid); end
    tests++; if (d_instr !== 32'h0) begin fails++; $display("FAIL drain_zero got %h exp 0", d_instr); end
  endtask

  task automatic test_jump;
    f_valid = 1'b1; f_npc = 32'h0000_0004; f_instr = 32'h0800_0010; d_ready = 1'b0;
    tick;
    f_npc = 32'h0000_0008; f_instr = 32'h2004_0004;
    tick;
    f_valid = 1'b0;
    #1;
    tests++; if (PCwre !== 1'b0) begin fails++; $display("FAIL jmp_no_pop_PCwre got %h exp 0", PCwre); end
    tests++; if (targPC !== 32'h0) begin fails++; $display("FAIL jmp_no_pop_targ got %h exp 0", targPC); end
    d_ready = 1'b1;
    #1;
    tests++; if (PCwre !== REDIR) begin fails++; $display("FAIL jmp_PCwre got %h exp %h", PCwre, REDIR); end
    tests++; if (targPC !== (REDIR ? 32'h0000_0040 : 32'h0)) begin fails++; $display("FAIL jmp_targPC got %h exp %h", targPC, REDIR ? 32'h40 : 32'h0); end
    tick;
    if (REDIR) begin
      tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL jmp_dropped got %h exp 0", d_valid); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL jmp_stall got %h exp 0", stall); end
    end else begin
      tests++; if (d_instr !== 32'h2004_0004) begin fails++; $display("FAIL jmp_pass_2nd got %h exp 20040004", d_instr); end
      tests++; if (d_npc !== 32'h8) begin fails++; $display("FAIL jmp_pass_npc got %h exp 8", d_npc); end
      tick;
      tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL jmp_pass_empty got %h exp 0", d_valid); end
    end
    // jal popped from a half-full queue while fetch pushes the next word
    d_ready = 1'b0;
    f_valid = 1'b1; f_npc = 32'h1000_0004; f_instr = 32'h0C00_0003;
    tick;
    f_npc = 32'h1000_0008; f_instr = 32'h2006_0006; d_ready = 1'b1;
    #1;
    tests++; if (PCwre !== REDIR) begin fails++; $display("FAIL jal_PCwre got %h exp %h", PCwre, REDIR); end
    tests++; if (targPC !== (REDIR ? 32'h1000_000C : 32'h0)) begin fails++; $display("FAIL jal_targPC got %h exp %h", targPC, REDIR ? 32'h1000_000C : 32'h0); end
    tick;
    f_valid = 1'b0;
    if (REDIR) begin
      tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL jal_push_dropped got %h exp 0", d_valid); end
    end else begin
      tests++; if (d_instr !== 32'h2006_0006) begin fails++; $display("FAIL jal_pass got %h exp 20060006", d_instr); end
      tick;
    end
    d_ready = 1'b0;
  endtask

  task automatic test_flush;
    f_valid = 1'b1; f_npc = 32'h200; f_instr = 32'h0800_0020;
    tick;
    f_npc = 32'h204; f_instr = 32'h2008_0008;
    tick;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_pre_full got %h exp 1", stall); end
    flush = 1'b1; f_npc = 32'h208; f_instr = 32'h2009_0009; d_ready = 1'b1;
    #1;
    tests++; if (PCwre !== 1'b0) begin fails++; $display("FAIL flush_PCwre got %h exp 0", PCwre); end
    tick;
    flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL flush_d_valid got %h exp 0", d_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall got %h exp 0", stall); end
    tests++; if (d_npc !== 32'h0) begin fails++; $display("FAIL flush_d_npc got %h exp 0", d_npc); end
  endtask

  task automatic test_reset_mid;
    f_valid = 1'b1; f_npc = 32'h300; f_instr = 32'h200A_000A;
    tick;
    f_npc = 32'h304; f_instr = 32'h200B_000B;
    tick;
    f_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL mrst_d_valid got %h exp 0", d_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mrst_stall got %h exp 0", stall); end
    tests++; if (d_npc !== 32'h0) begin fails++; $display("FAIL mrst_d_npc got %h exp 0", d_npc); end
    tests++; if (d_instr !== 32'h0) begin fails++; $display("FAIL mrst_d_instr got %h exp 0", d_instr); end
    tests++; if (PCwre !== 1'b0 || targPC !== 32'h0) begin fails++; $display("FAIL mrst_redirect got %h/%h exp 0/0", PCwre, targPC); end
    #2;
    rst_n = 1'b1;
    tick;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL mrst_discard got %h exp 0", d_valid); end
    f_valid = 1'b1; f_npc = 32'h400; f_instr = 32'h1234_5678;
    tick;
    f_valid = 1'b0;
    tests++; if (d_instr !== 32'h1234_5678) begin fails++; $display("FAIL mrst_push got %h exp 12345678", d_instr); end
    tests++; if (d_valid !== 1'b1) begin fails++; $display("FAIL mrst_valid got %h exp 1", d_valid); end
    d_ready = 1'b1;
    tick;
    d_ready = 1'b0;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL mrst_drain got %h exp 0", d_valid); end
  endtask

  task automatic test_back_to_back;
    f_valid = 1'b1; f_npc = 32'h1000; f_instr = 32'h2000_0000; d_ready = 1'b0;
    tick;
    d_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      f_npc = 32'h1000 + 32'(4 * k);
      f_instr = 32'h2000_0000 | 32'(k);
      #1;
      tests++; if (d_instr !== (32'h2000_0000 | 32'(k - 1))) begin fails++; $display("FAIL b2b_instr[%0d] got %h exp %h", k, d_instr, 32'h2000_0000 | 32'(k - 1)); end
      tests++; if (d_npc !== 32'h1000 + 32'(4 * (k - 1))) begin fails++; $display("FAIL b2b_npc[%0d] got %h exp %h", k, d_npc, 32'h1000 + 32'(4 * (k - 1))); end
      tests++; if (stall !== 1'b0 || d_valid !== 1'b1) begin fails++; $display("FAIL b2b_count[%0d] got stall=%h valid=%h exp 0/1", k, stall, d_valid); end
      tick;
    end
    f_valid = 1'b0;
    tests++; if (d_instr !== 32'h2000_000A) begin fails++; $display("FAIL b2b_last got %h exp 2000000a", d_instr); end
    tick;
    d_ready = 1'b0;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %h exp 0", d_valid); end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_jump;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, number of buffered fetch entries (power of two, 2 to 8).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port f_valid, input, 1, fetch stage presents f_npc/f_instr this cycle.
REQ-005 The block SHALL have port f_npc, input, 32, fetch PC+4.
REQ-006 The block SHALL have port f_instr, input, 32, fetched instruction word.
REQ-007 The block SHALL have port stall, output, 1, to fetch stage; PC hold request.
REQ-008 The block SHALL have port targPC, output, 32, redirect target to fetch stage.
REQ-009 The block SHALL have port PCwre, output, 1, to fetch stage; load targPC this cycle.
REQ-010 The block SHALL have port flush, input, 1, later-stage redirect; discard all entries.
REQ-011 The block SHALL have port d_valid, output, 1, head entry available to decode.
REQ-012 The block SHALL have port d_ready, input, 1, decode accepts head entry.
REQ-013 The block SHALL have ports d_npc and d_instr, output, 32 each, head entry contents.

Function
REQ-014 The block SHALL push {f_npc, f_instr} when f_valid=1, stall=0, flush=0, and no redirect is issued that cycle.
REQ-015 The block SHALL pop the head when d_valid=1 and d_ready=1; push and pop in one cycle SHALL leave the count unchanged.
REQ-016 stall SHALL equal (count==DEPTH), combinationally; no push SHALL occur while full, even with a simultaneous pop.
REQ-017 d_valid SHALL equal (count!=0); d_npc/d_instr SHALL be 0 when empty; push-to-d_valid latency SHALL be 1 cycle.
REQ-018 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; entries SHALL leave in push order.
REQ-019 When flush=1, the block SHALL clear count and both pointers at the next edge, ignore push and pop that cycle, and hold PCwre=0.
REQ-020 When the head is popped and d_instr[31:26] is 6'b000010 (j) or 6'b000011 (jal), the block SHALL assert PCwre=1 combinationally for that cycle, with targPC={d_npc[31:28], d_instr[25:0], 2'b00}.
REQ-021 On a redirect cycle, the block SHALL discard all entries behind the head and any same-cycle push; count SHALL be 0 at the next edge.
REQ-022 targPC SHALL be 0 whenever PCwre=0.
REQ-023 A non-popped jump at head (d_ready=0) SHALL NOT assert PCwre.

Reset
REQ-024 On rst_n=0, the block SHALL asynchronously clear count, pointers and storage; outputs SHALL read d_valid=0, stall=0, PCwre=0, targPC=0, d_npc=0, d_instr=0.
REQ-025 A reset asserted mid-operation SHALL discard all entries; the first push after release SHALL appear at d_* one cycle later.

Configuration
REQ-026 With macro IFQ_JUMP_REDIRECT_EN defined, REQ-020/021 SHALL apply; without it, PCwre and targPC SHALL be tied 0 and jumps SHALL pass through as ordinary entries.

Structure
REQ-027 The opcodes OP_J and OP_JAL (6 bits) and the jump target helper constants SHALL live in the shared package mips_pkg.
REQ-028 Entry storage SHALL be the sub-module ifq_store (DEPTH x 64-bit register array, async clear); control logic SHALL stay in if_id_queue.

Verification
REQ-029 Verification SHALL cover three pushes with d_ready=0 and DEPTH=2: stall=1 after the second; the third is held by fetch; d_ready=1 drains the entries in order.
REQ-030 Verification SHALL cover a push of npc=0x0000_0004 with instr=0x0800_0010 (j) that is then popped: PCwre=1 and targPC=0x0000_0040 in the pop cycle; the younger entry is dropped; count=0.
REQ-031 Verification SHALL cover the same jump with IFQ_JUMP_REDIRECT_EN undefined: PCwre=0, targPC=0, and both entries delivered.
REQ-032 Verification SHALL cover flush=1 with count=2 and a simultaneous push: next cycle d_valid=0, stall=0, d_npc=0.
REQ-033 Verification SHALL cover rst_n low for 3ns mid-cycle with the queue full: all outputs 0 immediately; after release, a push of 0x1234_5678 appears at d_instr one cycle later.
REQ-034 Verification SHALL cover 10 continuous push/pop cycles at count=1: count stays 1, pointers wrap past DEPTH-1 to 0, and data order is preserved.
